// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/ALUOp encodings and per-stage control bundles for the MIPS pipeline control unit.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W     = 6;
    localparam int unsigned ALUOP_BASE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [ALUOP_BASE_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_BASE_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_BASE_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [ALUOP_BASE_W-1:0] ALU_XOR   = 3'b011;
    localparam logic [ALUOP_BASE_W-1:0] ALU_AND   = 3'b100;
    localparam logic [ALUOP_BASE_W-1:0] ALU_OR    = 3'b101;

    // Fields consumed in EX
    typedef struct packed {
        logic                    reg_dst;
        logic                    alu_src;
        logic                    sign_zero;
        logic [ALUOP_BASE_W-1:0] alu_op;
    } ex_ctrl_t;

    // Fields consumed in MEM
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
    } mem_ctrl_t;

    // Fields consumed in WB
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, destination register, rt usage and legality.
module ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter bit          ENABLE_JAL = 1'b1
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_AW-1:0]   rt,
    input  logic [REG_AW-1:0]   rd,
    output ctrl_t               ctrl,
    output logic [REG_AW-1:0]   dest,
    output logic                uses_rt,
    output logic                legal,
    output logic                is_jump
);

    always_comb begin
        ctrl    = '0;
        dest    = '0;
        uses_rt = 1'b0;
        legal   = 1'b1;
        is_jump = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.ex.reg_dst   = 1'b1;
                ctrl.ex.alu_op    = ALU_FUNCT;
                ctrl.wb.reg_write = 1'b1;
                dest              = rd;
                uses_rt           = 1'b1;
            end
            OP_LW: begin
                ctrl.ex.alu_src    = 1'b1;
                ctrl.ex.alu_op     = ALU_ADD;
                ctrl.mem.mem_read  = 1'b1;
                ctrl.wb.reg_write  = 1'b1;
                ctrl.wb.mem_to_reg = 1'b1;
                dest               = rt;
            end
            OP_SW: begin
                ctrl.ex.alu_src    = 1'b1;
                ctrl.ex.alu_op     = ALU_ADD;
                ctrl.mem.mem_write = 1'b1;
                uses_rt            = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.ex.alu_op  = ALU_SUB;
                ctrl.mem.branch = 1'b1;
                uses_rt         = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.ex.alu_src   = 1'b1;
                ctrl.ex.sign_zero = (opcode != OP_ADDI);
                ctrl.wb.reg_write = 1'b1;
                dest              = rt;
                case (opcode)
                    OP_ANDI: ctrl.ex.alu_op = ALU_AND;
                    OP_ORI:  ctrl.ex.alu_op = ALU_OR;
                    OP_XORI: ctrl.ex.alu_op = ALU_XOR;
                    default: ctrl.ex.alu_op = ALU_ADD;
                endcase
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            OP_JAL: begin
                if (ENABLE_JAL) begin
                    is_jump           = 1'b1;
                    ctrl.wb.reg_write = 1'b1;
                    ctrl.wb.link      = 1'b1;
                    dest              = REG_AW'(31);
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID-stage control unit: decode, ID/EX -> EX/MEM -> MEM/WB control registers, load-use and flush handling.
module ctrl_pipe_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned ALUOP_W    = 3,
    parameter bit          ENABLE_JAL = 1'b1,
    parameter bit          LOAD_STALL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [5:0]         id_opcode,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_branch_taken,
    output logic               stall,
    output logic               flush_if_id,
    output logic               id_jump,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic               ex_sign_zero,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_branch,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic               wb_link,
    output logic [REG_AW-1:0]  ex_wr_reg,
    output logic [REG_AW-1:0]  mem_wr_reg,
    output logic [REG_AW-1:0]  wb_wr_reg,
    output logic               illegal_op
);

    ctrl_t             dec_ctrl;
    logic [REG_AW-1:0] dec_dest;
    logic              dec_uses_rt;
    logic              dec_legal;
    logic              dec_jump;

    ctrl_t             ex_q;
    mem_ctrl_t         mem_q;
    wb_ctrl_t          mem_wb_q;
    wb_ctrl_t          wb_q;
    logic [REG_AW-1:0] ex_wr_q;
    logic [REG_AW-1:0] mem_wr_q;
    logic [REG_AW-1:0] wb_wr_q;
    logic              illegal_q;

    logic              load_use;
    logic              bubble;

    ctrl_decode #(
        .REG_AW     (REG_AW),
        .ENABLE_JAL (ENABLE_JAL)
    ) u_decode (
        .opcode  (id_opcode),
        .rt      (id_rt),
        .rd      (id_rd),
        .ctrl    (dec_ctrl),
        .dest    (dec_dest),
        .uses_rt (dec_uses_rt),
        .legal   (dec_legal),
        .is_jump (dec_jump)
    );

    // Load in EX whose result is needed by the instruction in ID
    assign load_use = LOAD_STALL && id_valid && ex_q.mem.mem_read && (ex_wr_q != '0)
                      && ((ex_wr_q == id_rs) || (dec_uses_rt && (ex_wr_q == id_rt)));

    // Taken branch wins over the interlock; a stalled jump redirects once it is re-decoded
    assign stall       = load_use && !ex_branch_taken;
    assign id_jump     = id_valid && dec_jump && !ex_branch_taken && !stall;
    assign flush_if_id = ex_branch_taken || id_jump;
    assign bubble      = ex_branch_taken || stall || !id_valid || !dec_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ex_wr_q   <= '0;
            mem_q     <= '0;
            mem_wb_q  <= '0;
            mem_wr_q  <= '0;
            wb_q      <= '0;
            wb_wr_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= bubble ? '0 : dec_ctrl;
            ex_wr_q   <= bubble ? '0 : dec_dest;
            mem_q     <= ex_q.mem;
            mem_wb_q  <= ex_q.wb;
            mem_wr_q  <= ex_wr_q;
            wb_q      <= mem_wb_q;
            wb_wr_q   <= mem_wr_q;
            if (id_valid && !dec_legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign ex_reg_dst    = ex_q.ex.reg_dst;
    assign ex_alu_src    = ex_q.ex.alu_src;
    assign ex_sign_zero  = ex_q.ex.sign_zero;
    assign ex_alu_op     = ALUOP_W'(ex_q.ex.alu_op);
    assign ex_wr_reg     = ex_wr_q;
    assign mem_read      = mem_q.mem_read;
    assign mem_write     = mem_q.mem_write;
    assign mem_branch    = mem_q.branch;
    assign mem_wr_reg    = mem_wr_q;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_link       = wb_q.link;
    assign wb_wr_reg     = wb_wr_q;
    assign illegal_op    = illegal_q;

endmodule
